// File: rtl/lmac_txfifo_pkt_reader.sv
// Read side of the LMAC TX packet FIFO: parses frame headers, streams payload qwords
// through a 2-entry skid buffer with sop/eop/byte-mask tags, and drops oversized frames.
module lmac_txfifo_pkt_reader #(
  parameter int AW      = 5,
  parameter int MAX_LEN = 9600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   wr_ptr_i,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_en,
  input  logic [63:0]   mem_rd_data,
  output logic [AW:0]   rd_ptr_o,
  output logic          fifo_empty,
  output logic [AW:0]   rd_used,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [63:0]   tx_data,
  output logic          tx_sop,
  output logic          tx_eop,
  output logic [7:0]    tx_bmask,
  output logic          pkt_done,
  output logic          len_err
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [7:0]  mask;
  } beat_t;

  localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);

  state_t      state_reg, state_next;
  logic [AW:0] rd_ptr_reg;
  logic [11:0] rem_reg, rem_next;
  logic [7:0]  last_mask_reg, last_mask_next;
  logic        first_reg, first_next;
  logic        inflight_reg;
  logic        pend_sop_reg, pend_sop_next;
  logic        pend_eop_reg, pend_eop_next;
  logic [7:0]  pend_mask_reg, pend_mask_next;
  logic [1:0]  cnt_reg;
  beat_t       buf0_reg, buf1_reg;

  logic        rd_issue, data_issue, len_err_c;
  logic        pop, space_ok;
  logic [1:0]  cnt_pop, occ;
  logic [13:0] hdr_len;
  logic [14:0] hdr_sum;
  logic [11:0] hdr_n;
  logic [7:0]  hdr_mask;
  beat_t       in_beat;

  assign fifo_empty  = (rd_ptr_reg == wr_ptr_i);
  assign rd_used     = wr_ptr_i - rd_ptr_reg;
  assign rd_ptr_o    = rd_ptr_reg;
  assign mem_rd_addr = rd_ptr_reg[AW-1:0];
  assign mem_rd_en   = rd_issue & ~rst;

  assign hdr_len = mem_rd_data[13:0];
  assign hdr_sum = {1'b0, hdr_len} + 15'd7;
  assign hdr_n   = hdr_sum[14:3];

  // Last-beat byte mask: a length that is a multiple of 8 fills the whole qword.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign hdr_mask[gi] = (hdr_len[2:0] == 3'd0) || (3'(gi) < hdr_len[2:0]);
  end

  // Occupancy counts the beat leaving this cycle so the buffer can run at full rate.
  assign pop      = (cnt_reg != 2'd0) & tx_ready;
  assign cnt_pop  = cnt_reg - {1'b0, pop};
  assign occ      = cnt_pop + {1'b0, inflight_reg};
  assign space_ok = (occ < 2'd2);
  assign in_beat  = '{data: mem_rd_data, sop: pend_sop_reg, eop: pend_eop_reg, mask: pend_mask_reg};

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    last_mask_next = last_mask_reg;
    first_next     = first_reg;
    pend_sop_next  = pend_sop_reg;
    pend_eop_next  = pend_eop_reg;
    pend_mask_next = pend_mask_reg;
    rd_issue       = 1'b0;
    data_issue     = 1'b0;
    len_err_c      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          rd_issue   = 1'b1;
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        last_mask_next = hdr_mask;
        if (hdr_len == 14'd0) begin
          len_err_c  = 1'b1;
          state_next = S_IDLE;
        end else if (hdr_len > MAX_LEN_W) begin
          len_err_c  = 1'b1;
          rem_next   = hdr_n;
          state_next = S_DROP;
        end else if (!fifo_empty && space_ok) begin
          // First payload read goes out alongside header capture.
          rd_issue       = 1'b1;
          data_issue     = 1'b1;
          pend_sop_next  = 1'b1;
          pend_eop_next  = (hdr_n == 12'd1);
          pend_mask_next = (hdr_n == 12'd1) ? hdr_mask : 8'hFF;
          first_next     = 1'b0;
          rem_next       = hdr_n - 12'd1;
          state_next     = (hdr_n == 12'd1) ? S_IDLE : S_DATA;
        end else begin
          first_next = 1'b1;
          rem_next   = hdr_n;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (rem_reg != 12'd0 && !fifo_empty && space_ok) begin
          rd_issue       = 1'b1;
          data_issue     = 1'b1;
          pend_sop_next  = first_reg;
          pend_eop_next  = (rem_reg == 12'd1);
          pend_mask_next = (rem_reg == 12'd1) ? last_mask_reg : 8'hFF;
          first_next     = 1'b0;
          rem_next       = rem_reg - 12'd1;
          if (rem_reg == 12'd1) state_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (rem_reg == 12'd0) begin
          state_next = S_IDLE;
        end else if (!fifo_empty) begin
          rd_issue = 1'b1;
          rem_next = rem_reg - 12'd1;
          if (rem_reg == 12'd1) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rd_ptr_reg    <= '0;
      rem_reg       <= '0;
      last_mask_reg <= '0;
      first_reg     <= 1'b0;
      inflight_reg  <= 1'b0;
      pend_sop_reg  <= 1'b0;
      pend_eop_reg  <= 1'b0;
      pend_mask_reg <= '0;
      cnt_reg       <= '0;
      buf0_reg      <= '0;
      buf1_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      last_mask_reg <= last_mask_next;
      first_reg     <= first_next;
      inflight_reg  <= data_issue;
      pend_sop_reg  <= pend_sop_next;
      pend_eop_reg  <= pend_eop_next;
      pend_mask_reg <= pend_mask_next;
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      cnt_reg <= cnt_pop + {1'b0, inflight_reg};
      if (inflight_reg && cnt_pop == 2'd0) buf0_reg <= in_beat;
      else if (pop)                        buf0_reg <= buf1_reg;
      if (inflight_reg && cnt_pop == 2'd1) buf1_reg <= in_beat;
    end
  end

  assign tx_valid = (cnt_reg != 2'd0);
  assign tx_data  = buf0_reg.data;
  assign tx_sop   = buf0_reg.sop;
  assign tx_eop   = buf0_reg.eop;
  assign tx_bmask = buf0_reg.mask;
  assign pkt_done = pop & buf0_reg.eop;
  assign len_err  = len_err_c & ~rst;

endmodule
